uart_tx_fifo: RTL and testbench

//  Buffered UART transmitter: accepts words over a valid/ready stream into a

---
 rtl/uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. Words arrive over a valid/ready stream, are
//   queued in a FIFO and serialised as gap-free frames (start, WORD_LEN data
//   bits LSB first, optional parity, STOP stop bits). All outputs except
//   s_ready_o are registered, so the line lags the FSM by one cycle.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous reset, active-high
//   s_data_i      word to send
//   s_valid_i     s_data_i valid
//   s_ready_o     FIFO can accept (registered level < FIFO_DEPTH)
//   flush_i       discard all queued words
//   fifo_level_o  words queued, excluding the frame on the line
//   tx_busy_o     frame on the line
//   tx_done_o     one-cycle pulse on the last stop-bit cycle
//   tx_o          serial line, idle high
//
// FSM states
//   state    | meaning
//   S_IDLE   | line idle; pops the head word as soon as the FIFO is non-empty
//   S_START  | start bit (low) for DIV cycles
//   S_DATA   | WORD_LEN data bits, LSB first
//   S_PARITY | parity bit (only when PARITY is "M" or "N")
//   S_STOP   | STOP stop bits (high); pops the next word here for gap-free frames

module uart_tx_fifo #(
  parameter int unsigned CLK_RATE   = 10000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned WORD_LEN   = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  PARITY     = "L",
  parameter int unsigned STOP       = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [WORD_LEN-1:0]           s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic                          flush_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic                          tx_o
);

  localparam int unsigned DIV     = CLK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W   = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam bit          HAS_PAR = (PARITY != "L");

  if (WORD_LEN < 5 || WORD_LEN > 8) begin : g_err_word_len
    $error("uart_tx_fifo: WORD_LEN must be 5..8");
  end
  if (PARITY != "L" && PARITY != "M" && PARITY != "N") begin : g_err_parity
    $error("uart_tx_fifo: PARITY must be \"L\", \"M\" or \"N\"");
  end
  if (STOP != 1 && STOP != 2) begin : g_err_stop
    $error("uart_tx_fifo: STOP must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (DIV < 2) begin : g_err_div
    $error("uart_tx_fifo: CLK_RATE/BAUD_RATE must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [WORD_LEN-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [WORD_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_LEN-1:0] mem_d [FIFO_DEPTH];

  logic                pop;
  logic                wr_en;
  logic                not_empty;
  logic                bit_end;
  logic                last_data;
  logic                last_stop;
  logic [WORD_LEN-1:0] head_word;

  assign not_empty = (level_q != '0);
  assign s_ready_o = (level_q != LVL_W'(FIFO_DEPTH));
  assign wr_en     = s_valid_i && s_ready_o && !flush_i;
  assign head_word = mem_q[rd_ptr_q];
  assign bit_end   = (cnt_q == CNT_W'(DIV - 1));
  assign last_data = (bit_q == 3'(WORD_LEN - 1));
  assign last_stop = (bit_q == 3'(STOP - 1));

  // Next state and pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && last_data) state_d = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end && last_stop) begin
          if (not_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timer, bit index and shift register. The timer restarts on every
  // pop and on every state change, so each bit lasts exactly DIV cycles.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (pop) begin
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = head_word;
      par_d   = (PARITY == "N") ? ~^head_word : ^head_word;
    end else if (state_q == S_IDLE) begin
      cnt_d = '0;
      bit_d = '0;
    end else if (bit_end) begin
      cnt_d = '0;
      if (state_d != state_q) begin
        bit_d = '0;
      end else begin
        bit_d = bit_q + 3'd1;
        if (state_q == S_DATA) shift_d = shift_q >> 1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Line outputs, registered one cycle behind the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_q)
      S_IDLE:   busy_d = 1'b0;
      S_START:  tx_d   = 1'b0;
      S_DATA:   tx_d   = shift_q[0];
      S_PARITY: tx_d   = par_q;
      S_STOP:   done_d = bit_end && last_stop;
      default:  busy_d = 1'b0;
    endcase
  end

  // FIFO bookkeeping. Flush wins over a same-cycle write; a same-cycle pop
  // has already captured its word into the shift register.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = s_data_i;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign fifo_level_o = level_q;
  assign tx_busy_o    = busy_q;
  assign tx_done_o    = done_q;
  assign tx_o         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Four instances share stimulus: 8N1, 8E1, 8O1 and
// 5N2, all at DIV=10. A frame-level reference model per instance predicts
// every output each cycle; table vectors and short sequences pin down the
// documented timing corners.

module tb_uart_tx_fifo;

  localparam int NDUT  = 4;
  localparam int DIV   = 10;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      s_data = '0;
  logic            s_valid = 1'b0;
  logic            flush = 1'b0;
  logic [NDUT-1:0] rdy, busy, done, txl;
  logic [4:0]      lvl [NDUT];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int dfail [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_fifo #(.CLK_RATE(1000000), .BAUD_RATE(100000), .WORD_LEN(8), .FIFO_DEPTH(DEPTH),
                 .PARITY("L"), .STOP(1)) u_8n1 (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(rdy[0]),
    .flush_i(flush), .fifo_level_o(lvl[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]), .tx_o(txl[0]));
  uart_tx_fifo #(.CLK_RATE(1000000), .BAUD_RATE(100000), .WORD_LEN(8), .FIFO_DEPTH(DEPTH),
                 .PARITY("M"), .STOP(1)) u_8e1 (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(rdy[1]),
    .flush_i(flush), .fifo_level_o(lvl[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]), .tx_o(txl[1]));
  uart_tx_fifo #(.CLK_RATE(1000000), .BAUD_RATE(100000), .WORD_LEN(8), .FIFO_DEPTH(DEPTH),
                 .PARITY("N"), .STOP(1)) u_8o1 (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(rdy[2]),
    .flush_i(flush), .fifo_level_o(lvl[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]), .tx_o(txl[2]));
  uart_tx_fifo #(.CLK_RATE(1000000), .BAUD_RATE(100000), .WORD_LEN(5), .FIFO_DEPTH(DEPTH),
                 .PARITY("L"), .STOP(2)) u_5n2 (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data[4:0]), .s_valid_i(s_valid), .s_ready_o(rdy[3]),
    .flush_i(flush), .fifo_level_o(lvl[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]), .tx_o(txl[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  function automatic int wl_of(input int d);   return (d == 3) ? 5 : 8; endfunction
  function automatic int par_of(input int d);  return (d == 1) ? 1 : (d == 2) ? 2 : 0; endfunction
  function automatic int stop_of(input int d); return (d == 3) ? 2 : 1; endfunction
  function automatic int flen(input int d);
    return (1 + wl_of(d) + ((par_of(d) != 0) ? 1 : 0) + stop_of(d)) * DIV;
  endfunction

  // Line level t cycles into a frame carrying word w.
  function automatic logic frame_bit(input int d, input logic [7:0] w, input int t);
    int idx;
    idx = t / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= wl_of(d)) return w[idx-1];
    if (par_of(d) != 0 && idx == wl_of(d) + 1) return (par_of(d) == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  logic [7:0] mbuf [NDUT][DEPTH];
  int   mhead [NDUT];
  int   mcnt  [NDUT];
  bit   mact  [NDUT];
  int   mt    [NDUT];
  logic [7:0] mword [NDUT];
  logic e_tx [NDUT];
  logic e_busy [NDUT];
  logic e_done [NDUT];

  always @(posedge clk) begin : model
    int f;
    bit pn, acc;
    logic [7:0] w, mask;
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        mcnt[d] = 0; mhead[d] = 0; mact[d] = 0; mt[d] = 0;
        e_tx[d] = 1'b1; e_busy[d] = 1'b0; e_done[d] = 1'b0;
      end else begin
        f = flen(d);
        mask = 8'((1 << wl_of(d)) - 1);
        e_tx[d]   = mact[d] ? frame_bit(d, mword[d], mt[d]) : 1'b1;
        e_busy[d] = mact[d];
        e_done[d] = mact[d] && (mt[d] == f - 1);
        acc = s_valid && (mcnt[d] < DEPTH) && !flush;
        pn  = (mcnt[d] > 0) && (!mact[d] || mt[d] == f - 1);
        w   = '0;
        if (pn) begin
          w = mbuf[d][mhead[d]];
          mhead[d] = (mhead[d] + 1) % DEPTH;
          mcnt[d]--;
        end
        if (flush) begin
          mcnt[d] = 0; mhead[d] = 0;
        end else if (acc) begin
          mbuf[d][(mhead[d] + mcnt[d]) % DEPTH] = s_data & mask;
          mcnt[d]++;
        end
        if (pn) begin
          mact[d] = 1; mt[d] = 0; mword[d] = w;
        end else if (mact[d]) begin
          if (mt[d] == f - 1) mact[d] = 0;
          else mt[d]++;
        end
      end
    end
  end

  always @(negedge clk) begin : model_chk
    int f0;
    if (chk_on) begin
      for (int d = 0; d < NDUT; d++) begin
        if (dfail[d] < 10) begin
          f0 = n_fail;
          chk($sformatf("model_tx dut%0d", d), 32'(txl[d]), 32'(e_tx[d]));
          chk($sformatf("model_busy dut%0d", d), 32'(busy[d]), 32'(e_busy[d]));
          chk($sformatf("model_done dut%0d", d), 32'(done[d]), 32'(e_done[d]));
          chk($sformatf("model_level dut%0d", d), 32'(lvl[d]), 32'(mcnt[d]));
          chk($sformatf("model_ready dut%0d", d), 32'(rdy[d]), 32'(mcnt[d] < DEPTH));
          dfail[d] += n_fail - f0;
        end
      end
    end
  end

  // ---------------- dut0 monitor for the sequences ----------------
  bit mon_on = 1'b0;
  int ndone, last_done, nlow, first_low, nbusy, maxlvl;
  bit saw_nrdy;

  task automatic mon_clear();
    ndone = 0; last_done = -1; nlow = 0; first_low = -1; nbusy = 0; maxlvl = 0; saw_nrdy = 0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (done[0]) begin ndone++; last_done = cyc; end
      if (!txl[0]) begin nlow++; if (first_low < 0) first_low = cyc; end
      if (busy[0]) nbusy++;
      if (!rdy[0]) saw_nrdy = 1;
      if (int'(lvl[0]) > maxlvl) maxlvl = int'(lvl[0]);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int   phase;
    int   dut;
    int   edge_n;
    logic tx;
    logic busy;
    logic done;
    int   lvl;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int ph, input int d, input int e, input logic t, input logic b,
                     input logic dn, input int l);
    vec_t v;
    v.phase = ph; v.dut = d; v.edge_n = e; v.tx = t; v.busy = b; v.done = dn; v.lvl = l;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Writes nw (1 or 2) words on consecutive edges starting at edge 0 and
  // checks the table rows of this phase at each following edge.
  task automatic run_phase(input int phase, input logic [7:0] w0, input logic [7:0] w1,
                           input int nw, input int nedges);
    int d;
    @(negedge clk);
    s_data = w0; s_valid = 1'b1;
    for (int n = 0; n <= nedges; n++) begin
      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].phase == phase && vecs[i].edge_n == n) begin
          d = vecs[i].dut;
          chk($sformatf("vec p%0d d%0d e%0d tx", phase, d, n), 32'(txl[d]), 32'(vecs[i].tx));
          chk($sformatf("vec p%0d d%0d e%0d busy", phase, d, n), 32'(busy[d]), 32'(vecs[i].busy));
          chk($sformatf("vec p%0d d%0d e%0d done", phase, d, n), 32'(done[d]), 32'(vecs[i].done));
          chk($sformatf("vec p%0d d%0d e%0d level", phase, d, n), 32'(lvl[d]), 32'(vecs[i].lvl));
        end
      end
      if (n + 1 < nw) s_data = w1;
      else s_valid = 1'b0;
    end
  endtask

  // Writes words back to back on edges 0..n-1 into an empty FIFO; returns
  // the cycle count seen just after edge 0.
  task automatic write_burst(input int n, output int base);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h51;
    @(negedge clk);
    base = cyc;
    for (int i = 1; i < n; i++) begin
      s_data = 8'(8'h51 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, acc, guard;
    bit r;

    // Test 1: 0xA5 on 8N1.
    add(1,0,0,  1,0,0,1); add(1,0,1,  1,0,0,0); add(1,0,2,  0,1,0,0); add(1,0,11, 0,1,0,0);
    add(1,0,12, 1,1,0,0); add(1,0,21, 1,1,0,0); add(1,0,22, 0,1,0,0); add(1,0,32, 1,1,0,0);
    add(1,0,42, 0,1,0,0); add(1,0,52, 0,1,0,0); add(1,0,62, 1,1,0,0); add(1,0,72, 0,1,0,0);
    add(1,0,82, 1,1,0,0); add(1,0,91, 1,1,0,0); add(1,0,100,1,1,0,0); add(1,0,101,1,1,1,0);
    add(1,0,102,1,0,0,0);
    // Test 2: 0x07 with even (dut1) and odd (dut2) parity; 110-cycle frame.
    add(2,1,91, 0,1,0,0); add(2,1,92, 1,1,0,0); add(2,1,101,1,1,0,0); add(2,1,111,1,1,1,0);
    add(2,1,112,1,0,0,0);
    add(2,2,92, 0,1,0,0); add(2,2,101,0,1,0,0); add(2,2,102,1,1,0,0); add(2,2,111,1,1,1,0);
    add(2,2,112,1,0,0,0);
    // Test 4: 5N2, 0x1F then 0x00 back to back; 80-cycle frames.
    add(4,3,0,  1,0,0,1); add(4,3,1,  1,0,0,1); add(4,3,2,  0,1,0,1); add(4,3,12, 1,1,0,1);
    add(4,3,61, 1,1,0,1); add(4,3,62, 1,1,0,1); add(4,3,80, 1,1,0,1); add(4,3,81, 1,1,1,0);
    add(4,3,82, 0,1,0,0); add(4,3,91, 0,1,0,0); add(4,3,92, 0,1,0,0); add(4,3,141,0,1,0,0);
    add(4,3,142,1,1,0,0); add(4,3,161,1,1,1,0); add(4,3,162,1,0,0,0);

    for (int d = 0; d < NDUT; d++) dfail[d] = 0;
    mon_clear();
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;

    // Reset state.
    chk("reset tx", 32'(txl[0]), 32'd1);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset done", 32'(done[0]), 32'd0);
    chk("reset level", 32'(lvl[0]), 32'd0);
    chk("reset ready", 32'(rdy[0]), 32'd1);

    do_reset(); run_phase(1, 8'hA5, 8'h00, 1, 105);
    do_reset(); run_phase(2, 8'h07, 8'h00, 1, 115);
    do_reset(); run_phase(4, 8'h1F, 8'h00, 2, 165);

    // Test 3: hold valid for 17 words; gap-free stream of 17 frames.
    do_reset();
    mon_clear(); mon_on = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h30; acc = 0; guard = 0;
    while (acc < 17 && guard < 400) begin
      r = rdy[0];
      @(negedge clk);
      guard++;
      if (r) begin
        acc++;
        s_data = 8'(8'h30 + acc);
      end
    end
    s_valid = 1'b0;
    chk("burst words accepted", 32'(acc), 32'd17);
    guard = 0;
    while (ndone < 17 && guard < 2500) begin @(negedge clk); guard++; end
    repeat (5) @(negedge clk);
    chk("burst done pulses", 32'(ndone), 32'd17);
    chk("burst start-to-last-done", 32'(last_done - first_low + 1), 32'd1700);
    chk("burst busy cycles", 32'(nbusy), 32'd1700);
    chk("burst max level", 32'(maxlvl), 32'(DEPTH));
    chk("burst ready dropped", 32'(saw_nrdy), 32'd1);
    mon_on = 1'b0;

    // Test 5: reset during the 4th data bit with 3 words queued.
    do_reset();
    mon_clear(); mon_on = 1'b1;
    write_burst(4, base);
    wait_cyc(base + 3);
    chk("rst-mid level before", 32'(lvl[0]), 32'd3);
    wait_cyc(base + 45);
    chk("rst-mid in data", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-mid tx", 32'(txl[0]), 32'd1);
    chk("rst-mid busy", 32'(busy[0]), 32'd0);
    chk("rst-mid level", 32'(lvl[0]), 32'd0);
    chk("rst-mid ready", 32'(rdy[0]), 32'd1);
    mon_clear();
    repeat (200) @(negedge clk);
    chk("rst-mid no start bit", 32'(nlow), 32'd0);
    chk("rst-mid no done", 32'(ndone), 32'd0);
    mon_on = 1'b0;

    // Test 6: flush during frame 1 with 3 queued, plus a same-cycle write.
    do_reset();
    mon_clear(); mon_on = 1'b1;
    write_burst(4, base);
    wait_cyc(base + 49);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    chk("flush level", 32'(lvl[0]), 32'd0);
    chk("flush frame continues", 32'(busy[0]), 32'd1);
    wait_cyc(base + 105);
    chk("flush done pulses", 32'(ndone), 32'd1);
    chk("flush done edge", 32'(last_done - base), 32'd101);
    mon_clear();
    repeat (200) @(negedge clk);
    chk("flush line idle", 32'(nlow), 32'd0);
    chk("flush level after", 32'(lvl[0]), 32'd0);
    mon_on = 1'b0;

    // Flush in the pop cycle: popped word still goes out, write is dropped.
    do_reset();
    mon_clear(); mon_on = 1'b1;
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h3C;
    @(negedge clk);
    base = cyc;
    flush = 1'b1; s_data = 8'h99;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    chk("flush-pop level", 32'(lvl[0]), 32'd0);
    wait_cyc(base + 15);
    chk("flush-pop bit0", 32'(txl[0]), 32'd0);
    wait_cyc(base + 35);
    chk("flush-pop bit2", 32'(txl[0]), 32'd1);
    wait_cyc(base + 250);
    chk("flush-pop frames", 32'(ndone), 32'd1);
    mon_on = 1'b0;

    // Random traffic against the model on all four instances.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 99) < ((i < 2500) ? 60 : 8));
      s_data  = 8'($urandom);
      flush   = ($urandom_range(0, 299) == 0);
      rst     = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk);
    s_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
